// File: rtl/pixel_pack_hw.sv
// pixel_pack_hw: Avalon-MM slave that converts RGB888 pixels to RGB565.
// Pixels written to DATA pass through an input FIFO, a conversion register
// and a packer into an output FIFO, which software drains by reading DATA.
// With PACK=1 two pixels share one 32-bit word ({second, first}).
// Optional build macro: PIXEL_PACK_ROUND_EN selects round-to-nearest with
// saturation instead of plain truncation.
module pixel_pack_hw #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 8,
  parameter int PACK      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    A_DATA   = 2'd0,
    A_STATUS = 2'd1,
    A_CTRL   = 2'd2,
    A_RSVD   = 2'd3
  } addr_e;

  // RGB888 -> RGB565, with optional R/B source swap and optional rounding.
  function automatic logic [15:0] conv(input logic [23:0] px, input logic swap);
    logic [7:0] r, g, b;
    logic [4:0] r5, b5;
    logic [5:0] g6;
`ifdef PIXEL_PACK_ROUND_EN
    logic [8:0] rs, gs, bs;
`else
    logic       unused_lsb;
`endif
    r = swap ? px[23:16] : px[7:0];
    g = px[15:8];
    b = swap ? px[7:0] : px[23:16];
`ifdef PIXEL_PACK_ROUND_EN
    rs = {1'b0, r} + 9'd4;
    gs = {1'b0, g} + 9'd2;
    bs = {1'b0, b} + 9'd4;
    // A carry into bit 8 means the rounded value exceeds the field: saturate.
    r5 = rs[8] ? 5'd31 : rs[7:3];
    g6 = gs[8] ? 6'd63 : gs[7:2];
    b5 = bs[8] ? 5'd31 : bs[7:3];
`else
    r5 = r[7:3];
    g6 = g[7:2];
    b5 = b[7:3];
    unused_lsb = ^{r[2:0], g[1:0], b[2:0]};
`endif
    return {r5, g6, b5};
  endfunction

  // ---------------------------------------------------------------------
  // Bus decode. A simultaneous write and read is treated as a write only.
  // ---------------------------------------------------------------------
  logic bus_wr, bus_rd;
  logic data_wr, ctrl_wr, data_rd;
  logic unused_wd;

  assign bus_wr    = chipselect & write;
  assign bus_rd    = chipselect & read & ~write;
  assign data_wr   = bus_wr & (address == A_DATA);
  assign ctrl_wr   = bus_wr & (address == A_CTRL);
  assign data_rd   = bus_rd & (address == A_DATA);
  assign unused_wd = ^writedata[31:24];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [23:0]    in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr_ptr, in_rd_ptr;
  logic [ICW-1:0] in_count;

  logic           cv_valid;
  logic [15:0]    cv_data;

  logic           half_valid;
  logic [15:0]    half_data;

  logic [31:0]    out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OCW-1:0] out_count;

  logic           swap_rb, flush_pending, overflow, underflow;

  // ---------------------------------------------------------------------
  // Pipeline handshakes
  // ---------------------------------------------------------------------
  logic        in_full, in_empty, out_full, out_empty;
  logic        in_push, in_pop, ovf_evt;
  logic        pk_accept, cv_adv, pk_push;
  logic        flush_go, fl_push, flush_done;
  logic        out_push, out_pop, unf_evt;
  logic [31:0] out_word;

  assign in_full   = (in_count == ICW'(IN_DEPTH));
  assign in_empty  = (in_count == '0);
  assign out_full  = (out_count == OCW'(OUT_DEPTH));
  assign out_empty = (out_count == '0);

  // A write while full is dropped even if the FIFO pops in the same cycle.
  assign in_push = data_wr & ~in_full;
  assign ovf_evt = data_wr & in_full;

  // The packer can always take a first half; a completed word needs room.
  assign pk_accept = ((PACK != 0) && !half_valid) || !out_full;
  assign cv_adv    = cv_valid & pk_accept;
  assign in_pop    = ~in_empty & (~cv_valid | cv_adv);
  assign pk_push   = cv_adv & ((PACK == 0) || half_valid);

  assign flush_go   = flush_pending & in_empty & ~cv_valid;
  assign fl_push    = flush_go & (PACK != 0) & half_valid & ~out_full;
  assign flush_done = flush_go & ((PACK == 0) || !half_valid || !out_full);

  assign out_push = pk_push | fl_push;
  assign out_pop  = data_rd & ~out_empty;
  assign unf_evt  = data_rd & out_empty;

  // Word presented to the output FIFO: flushed half, packed pair, or single.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    out_word = {16'h0000, cv_data};
    if (fl_push)
      out_word = {16'h0000, half_data};
    else if (PACK != 0)
      out_word = {cv_data, half_data};
  end

  // Input FIFO storage.
  // NOTE: the storage arrays are left out of reset; the pointers and counts
  // define which entries are valid, and skipping reset keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (in_push)
      in_mem[in_wr_ptr] <= writedata[23:0];
  end

  // Input FIFO pointers and occupancy.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
      in_count <= in_count + ICW'(in_push) - ICW'(in_pop);
    end
  end

  // Stage 2: convert the FIFO head into the conversion register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cv_valid <= 1'b0;
      cv_data  <= '0;
    end else if (in_pop) begin
      cv_valid <= 1'b1;
      cv_data  <= conv(in_mem[in_rd_ptr], swap_rb);
    end else if (cv_adv) begin
      cv_valid <= 1'b0;
    end
  end

  // Stage 3: hold the first pixel of a pair until its partner arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_valid <= 1'b0;
      half_data  <= '0;
    end else if (cv_adv && (PACK != 0)) begin
      if (!half_valid) begin
        half_data  <= cv_data;
        half_valid <= 1'b1;
      end else begin
        half_valid <= 1'b0;
      end
    end else if (fl_push) begin
      half_valid <= 1'b0;
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clk) begin
    if (out_push)
      out_mem[out_wr_ptr] <= out_word;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      out_count <= out_count + OCW'(out_push) - OCW'(out_pop);
    end
  end

  // Control register and sticky flags; a new event beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_rb       <= 1'b0;
      flush_pending <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (ctrl_wr)
        swap_rb <= writedata[1];

      if (ctrl_wr && writedata[0])
        flush_pending <= 1'b1;
      else if (flush_done)
        flush_pending <= 1'b0;

      if (ovf_evt)
        overflow <= 1'b1;
      else if (ctrl_wr && writedata[2])
        overflow <= 1'b0;

      if (unf_evt)
        underflow <= 1'b1;
      else if (ctrl_wr && writedata[2])
        underflow <= 1'b0;
    end
  end

  // STATUS word assembly.
  logic [31:0] status;
  always_comb begin
    status        = '0;
    status[0]     = in_full;
    status[1]     = out_empty;
    status[2]     = overflow;
    status[3]     = underflow;
    status[4]     = flush_pending;
    status[5]     = half_valid;
    status[15:8]  = 8'(in_count);
    status[23:16] = 8'(out_count);
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (bus_rd) begin
      case (address)
        A_DATA:   readdata <= out_empty ? 32'h0 : out_mem[out_rd_ptr];
        A_STATUS: readdata <= status;
        default:  readdata <= 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_pack_hw.sv
// Self-checking bench for pixel_pack_hw: one PACK=0 and one PACK=1 instance,
// directed vector table, hand-written corner sequences and randomized
// streams checked against a pixel-queue reference model.
module tb_pixel_pack_hw;

  logic clk;
  logic reset_n;
  logic [1:0]       cs, wr, rd;
  logic [1:0][1:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] convq [$];
  logic [31:0] expq  [$];

  pixel_pack_hw #(.IN_DEPTH(16), .OUT_DEPTH(8), .PACK(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs[0]), .address(addr[0]),
    .write(wr[0]), .writedata(wdata[0]), .read(rd[0]), .readdata(rdata[0])
  );

  pixel_pack_hw #(.IN_DEPTH(16), .OUT_DEPTH(8), .PACK(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs[1]), .address(addr[1]),
    .write(wr[1]), .writedata(wdata[1]), .read(rd[1]), .readdata(rdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference conversion from the channel arithmetic.
  function automatic logic [15:0] ref_conv(input logic [23:0] px, input bit swap);
    int r, g, b, t;
    r = int'(px[7:0]);
    g = int'(px[15:8]);
    b = int'(px[23:16]);
    if (swap) begin
      t = r; r = b; b = t;
    end
`ifdef PIXEL_PACK_ROUND_EN
    r = (r + 4) / 8; if (r > 31) r = 31;
    g = (g + 2) / 4; if (g > 63) g = 63;
    b = (b + 4) / 8; if (b > 31) b = 31;
`else
    r = r / 8;
    g = g / 4;
    b = b / 8;
`endif
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  // Turn the queue of converted pixels into the words software will read.
  task automatic build_expect(input bit pack);
    logic [15:0] lo, hi;
    while (convq.size() > 0) begin
      lo = convq.pop_front();
      if (pack) begin
        hi = (convq.size() > 0) ? convq.pop_front() : 16'h0000;
        expq.push_back({hi, lo});
      end else begin
        expq.push_back({16'h0000, lo});
      end
    end
  endtask

  task automatic bus_wr(input int d, input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    cs[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; wdata[d] = v;
    @(posedge clk);
    #1;
    cs[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic bus_rd(input int d, input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    cs[d] = 1'b1; rd[d] = 1'b1; addr[d] = a;
    @(posedge clk);
    #1;
    v = rdata[d];
    cs[d] = 1'b0; rd[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  typedef struct {
    logic        swap;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] v;
    logic [31:0] px;
    int n;
    bit swap;
    int k;

    // Directed conversions (PACK=0); values are exact under either rounding mode.
    tbl[0] = '{1'b0, 32'h00FF8040, 32'h0000441F};
    tbl[1] = '{1'b1, 32'h00FF8040, 32'h0000FC08};
    tbl[2] = '{1'b0, 32'h000000FF, 32'h0000F800};
    tbl[3] = '{1'b0, 32'h0000FF00, 32'h000007E0};
    tbl[4] = '{1'b0, 32'h00FF0000, 32'h0000001F};
    tbl[5] = '{1'b0, 32'hAB000000, 32'h00000000};
    tbl[6] = '{1'b0, 32'h00000408, 32'h00000820};
    tbl[7] = '{1'b1, 32'h00F80000, 32'h0000F800};

    cs = '0; wr = '0; rd = '0; addr = '0; wdata = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state.
    check("reset_readdata0", rdata[0], 32'h0);
    check("reset_readdata1", rdata[1], 32'h0);
    bus_rd(0, 2'd1, v); check("reset_status0", v, 32'h00000002);
    bus_rd(1, 2'd1, v); check("reset_status1", v, 32'h00000002);

    // Table-driven conversion vectors.
    for (int i = 0; i < 8; i++) begin
      bus_wr(0, 2'd2, {30'h0, tbl[i].swap, 1'b0});
      bus_wr(0, 2'd0, tbl[i].wd);
      idle(3);
      bus_rd(0, 2'd0, v);
      check($sformatf("table_%0d", i), v, tbl[i].exp);
    end
    bus_wr(0, 2'd2, 32'h0);

    // Latency: in_count after the write edge, out_count visible at N+3.
    bus_wr(0, 2'd0, 32'h00FFFFFF);
    bus_rd(0, 2'd1, v); check("lat_in_count", v, 32'h00000102);
    idle(1);
    bus_rd(0, 2'd1, v); check("lat_out_count", v, 32'h00010000);
    bus_rd(0, 2'd0, v); check("lat_word", v, 32'h0000FFFF);

    // PACK=1 pair.
    bus_wr(1, 2'd0, 32'h000000FF);
    bus_wr(1, 2'd0, 32'h0000FF00);
    idle(3);
    bus_rd(1, 2'd1, v); check("pack_status", v, 32'h00010000);
    bus_rd(1, 2'd0, v); check("pack_word", v, 32'h07E0F800);

    // PACK=1 single pixel plus flush.
    bus_wr(1, 2'd0, 32'h00FFFFFF);
    bus_wr(1, 2'd2, 32'h00000001);
    n = 0;
    do begin
      bus_rd(1, 2'd1, v);
      n++;
    end while (v[4] && n < 8);
    check("flush_pending_clear", {31'h0, v[4]}, 32'h0);
    check("flush_within_4", {31'h0, n <= 4}, 32'h1);
    bus_rd(1, 2'd0, v); check("flush_word", v, 32'h0000FFFF);

    // Underflow and clear_flags.
    bus_rd(0, 2'd1, v); check("unf_pre_status", v, 32'h00000002);
    bus_rd(0, 2'd0, v); check("unf_readdata", v, 32'h0);
    bus_rd(0, 2'd1, v); check("unf_flag", v, 32'h0000000A);
    bus_wr(0, 2'd2, 32'h00000004);
    bus_rd(0, 2'd1, v); check("unf_cleared", v, 32'h00000002);

    // Overflow with the output stalled, then ordered drain (PACK=1).
    bus_wr(1, 2'd2, 32'h00000004);
    for (int i = 0; i < 34; i++) begin
      px = $urandom & 32'h00FFFFFF;
      convq.push_back(ref_conv(px[23:0], 1'b0));
      bus_wr(1, 2'd0, px);
    end
    idle(4);
    bus_wr(1, 2'd0, $urandom & 32'h00FFFFFF);
    idle(2);
    bus_rd(1, 2'd1, v); check("ovf_status", v, 32'h00081025);
    build_expect(1'b1);
    for (int i = 0; i < 17; i++) begin
      idle(3);
      bus_rd(1, 2'd0, v);
      check($sformatf("ovf_drain_%0d", i), v, expq.pop_front());
    end
    idle(5);
    bus_rd(1, 2'd1, v); check("ovf_sticky", v, 32'h00000006);
    bus_wr(1, 2'd2, 32'h00000004);

    // Randomized streams against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 6; r++) begin
        swap = bit'($urandom_range(0, 1));
        bus_wr(d, 2'd2, {30'h0, swap, 1'b0});
        k = $urandom_range(1, 16);
        for (int i = 0; i < k; i++) begin
          px = $urandom;
          convq.push_back(ref_conv(px[23:0], swap));
          bus_wr(d, 2'd0, px);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        bus_wr(d, 2'd2, {30'h0, swap, 1'b1});
        build_expect(d == 1);
        idle(8);
        while (expq.size() > 0) begin
          idle(3);
          bus_rd(d, 2'd0, v);
          check($sformatf("rand_d%0d_r%0d", d, r), v, expq.pop_front());
        end
        idle(5);
        bus_rd(d, 2'd1, v);
        check($sformatf("rand_status_d%0d_r%0d", d, r), v, 32'h00000002);
      end
    end

    // Asynchronous reset mid-stream: in_count = 5, half_valid = 1.
    bus_wr(1, 2'd2, 32'h00000000);
    for (int i = 0; i < 23; i++) bus_wr(1, 2'd0, $urandom);
    idle(5);
    bus_rd(1, 2'd1, v); check("prereset_status", v, 32'h00080520);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_readdata", rdata[1], 32'h0);
    check("async_in_count", 32'(dut1.in_count), 32'h0);
    check("async_out_count", 32'(dut1.out_count), 32'h0);
    check("async_half_valid", {31'h0, dut1.half_valid}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(1, 2'd1, v); check("postreset_status", v, 32'h00000002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
